// File: rtl/dma_controller_pkg.sv
// Shared constants, state encodings and command payload for the DMA controller.
// Optional burst release is enabled by defining DMA_BURST_RELEASE_EN.
package dma_controller_pkg;

    localparam int unsigned WORD_SIZE     = 16;
    localparam int unsigned LEN_W         = 4;
    localparam int unsigned LEN_MAX       = 12;
    localparam int unsigned MEM_WR_CYCLES = 1;
    localparam int unsigned BURST         = 4;
    localparam int unsigned STATE_W       = 3;

    localparam logic [STATE_W-1:0] DMA_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] DMA_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] DMA_XFER = 3'd2;
    localparam logic [STATE_W-1:0] DMA_DONE = 3'd3;
    localparam logic [STATE_W-1:0] DMA_GAP  = 3'd4;

    typedef struct packed {
        logic [WORD_SIZE-1:0] base;
        logic [LEN_W-1:0]     len;
    } dma_cmd_t;

    // Lengths beyond the device buffer depth are clamped
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len > LEN_W'(LEN_MAX)) begin
            return LEN_W'(LEN_MAX);
        end
        return len;
    endfunction

endpackage

// File: rtl/dma_word_timer.sv
// Counts memory write cycles for one word; restart drops any partial count.
module dma_word_timer
    import dma_controller_pkg::*;
#(
    parameter int unsigned CYCLES = MEM_WR_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic restart,
    output logic word_done_c
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign word_done_c = en && !restart && (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dma_controller.sv
// Device-to-memory block DMA with BR/BG bus handshake and a one-cycle done pulse.
// Define DMA_BURST_RELEASE_EN to release the bus for a GAP after every BURST words.
module dma_controller
    import dma_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd,
    input  logic [15:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    input  logic        BG,
    output logic        BR,
    output logic        use_bus,
    output logic [3:0]  idx,
    output logic [15:0] mem_addr,
    output logic        mem_write,
    output logic        done
);

    logic [STATE_W-1:0]   state_q, state_d;
    dma_cmd_t             cmd_q, cmd_d;
    logic [LEN_W-1:0]     count_q, count_d;
    logic                 br_q, br_d;
    logic                 use_bus_q, use_bus_d;
    logic                 mem_write_q, mem_write_d;
    logic                 done_q, done_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]     len_clamped;
    logic                 timer_en;
    logic                 word_done_c;
    logic                 last_word;

`ifdef DMA_BURST_RELEASE_EN
    localparam int unsigned BURST_W = (BURST > 1) ? $clog2(BURST) : 1;
    logic [BURST_W-1:0] burst_q, burst_d;
`endif

    assign len_clamped = clamp_len(cmd_len);
    assign last_word   = (count_q == cmd_q.len - LEN_W'(1));
    // A word only advances while the grant is held; losing BG restarts it
    assign timer_en    = (state_q == DMA_XFER) && BG;

    dma_word_timer #(
        .CYCLES (MEM_WR_CYCLES)
    ) u_word_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (timer_en),
        .restart     (!timer_en),
        .word_done_c (word_done_c)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        count_d = count_q;
        done_d  = 1'b0;
`ifdef DMA_BURST_RELEASE_EN
        burst_d = burst_q;
`endif
        case (state_q)
            DMA_IDLE: begin
                if (cmd) begin
                    cmd_d.base = cmd_addr;
                    cmd_d.len  = len_clamped;
                    count_d    = '0;
`ifdef DMA_BURST_RELEASE_EN
                    burst_d    = '0;
`endif
                    state_d    = (len_clamped == '0) ? DMA_DONE : DMA_REQ;
                end
            end
            DMA_REQ: begin
                if (BG) begin
                    state_d = DMA_XFER;
                end
            end
            DMA_XFER: begin
                if (!BG) begin
                    state_d = DMA_REQ;
                end else if (word_done_c) begin
                    if (last_word) begin
                        state_d = DMA_DONE;
                    end else begin
                        count_d = count_q + LEN_W'(1);
`ifdef DMA_BURST_RELEASE_EN
                        if (burst_q == BURST_W'(BURST - 1)) begin
                            burst_d = '0;
                            state_d = DMA_GAP;
                        end else begin
                            burst_d = burst_q + BURST_W'(1);
                        end
`endif
                    end
                end
            end
            DMA_DONE: begin
                if (!BG) begin
                    state_d = DMA_IDLE;
                    done_d  = 1'b1;
                end
            end
`ifdef DMA_BURST_RELEASE_EN
            DMA_GAP: begin
                if (!BG) begin
                    state_d = DMA_REQ;
                end
            end
`endif
            default: begin
                state_d = DMA_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are plain flops
        br_d        = (state_d == DMA_REQ) || (state_d == DMA_XFER);
        use_bus_d   = (state_d == DMA_XFER);
        mem_write_d = (state_d == DMA_XFER);
        idx_d       = use_bus_d ? count_d : '0;
        mem_addr_d  = use_bus_d ? cmd_d.base + WORD_SIZE'(count_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= DMA_IDLE;
            cmd_q       <= '0;
            count_q     <= '0;
            br_q        <= 1'b0;
            use_bus_q   <= 1'b0;
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            count_q     <= count_d;
            br_q        <= br_d;
            use_bus_q   <= use_bus_d;
            mem_write_q <= mem_write_d;
            done_q      <= done_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

`ifdef DMA_BURST_RELEASE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign BR        = br_q;
    assign use_bus   = use_bus_q;
    assign mem_write = mem_write_q;
    assign done      = done_q;
    assign idx       = idx_q;
    assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: a CPU that grants BG one cycle after BR,
// a device that supplies word idx*0x1111, and a memory/bus monitor.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd;
    logic [15:0] cmd_addr;
    logic [3:0]  cmd_len;
    logic        BG;
    logic        BR;
    logic        use_bus;
    logic [3:0]  idx;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic        done;

    dma_controller dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (cmd),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .BG        (BG),
        .BR        (BR),
        .use_bus   (use_bus),
        .idx       (idx),
        .mem_addr  (mem_addr),
        .mem_write (mem_write),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    int          wr_cnt, seq_err, dup_cnt, done_cnt, cur_ten;
    int          last_wr_cyc, first_done_cyc;
    int          tenures[$];
    logic        br_ever, br_prev_mon, bg_block;
    logic [3:0]  last_idx, first_idx;
    logic [15:0] wmask;
    logic [15:0] exp_base;
    logic [15:0] mem [0:65535];

    // Bus monitor: a word is written when the strobe is seen with the grant held
    always @(posedge clk) begin
        cyc++;
        if (mem_write && BG) begin
            if (idx != 4'(wr_cnt) || mem_addr != exp_base + 16'(wr_cnt)) seq_err++;
            if (wmask[idx]) dup_cnt++;
            wmask[idx] = 1'b1;
            if (wr_cnt == 0) first_idx = idx;
            mem[mem_addr] = {4{idx}};
            last_idx = idx;
            last_wr_cyc = cyc;
            wr_cnt++;
            cur_ten++;
        end
        if (done) begin
            if (done_cnt == 0) first_done_cyc = cyc;
            done_cnt++;
        end
        if (BR) br_ever = 1'b1;
        if (br_prev_mon && !BR) begin
            tenures.push_back(cur_ten);
            cur_ten = 0;
        end
        br_prev_mon = BR;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon(input logic [15:0] base);
        wr_cnt = 0; seq_err = 0; dup_cnt = 0; done_cnt = 0; cur_ten = 0;
        last_wr_cyc = 0; first_done_cyc = 0;
        tenures.delete();
        br_ever = 1'b0; wmask = '0; exp_base = base;
        last_idx = '0; first_idx = 4'hF;
    endtask

    // CPU model: BG follows BR with one cycle of lag unless blocked
    task automatic tick();
        logic br_seen;
        br_seen = BR;
        @(posedge clk);
        #1;
        BG = br_seen && !bg_block;
    endtask

    task automatic start(input logic [15:0] a, input logic [3:0] l);
        cmd_addr = a;
        cmd_len  = l;
        cmd      = 1'b1;
        tick();
        cmd      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_cnt > 0), 32'd1);
    endtask

    function automatic int ten(input int i);
        if (i < tenures.size()) return tenures[i];
        return -1;
    endfunction

    initial begin
        reset_n  = 1'b0;
        cmd      = 1'b0;
        cmd_addr = '0;
        cmd_len  = '0;
        BG       = 1'b0;
        bg_block = 1'b0;
        br_prev_mon = 1'b0;
        clear_mon(16'h0000);
        #12;
        chk("reset_outputs", {8'd0, BR, use_bus, mem_write, done, idx, mem_addr}, 32'd0);
        reset_n = 1'b1;
        tick();

        // 1: 12 words at 0x01F4 with a prompt grant
        clear_mon(16'h01F4);
        start(16'h01F4, 4'd12);
        chk("t1_req_br", {31'd0, BR}, 32'd1);
        chk("t1_req_use_bus", {31'd0, use_bus}, 32'd0);
        tick();
        chk("t1_req_no_write", {31'd0, mem_write}, 32'd0);
        tick();
        chk("t1_first_write", {12'd0, mem_write, use_bus, idx, mem_addr}, {12'd0, 1'b1, 1'b1, 4'd0, 16'h01F4});
        wait_done(40);
        tick(); tick(); tick();
        chk("t1_writes", 32'(wr_cnt), 32'd12);
        chk("t1_seq", 32'(seq_err), 32'd0);
        chk("t1_dups", 32'(dup_cnt), 32'd0);
        chk("t1_mem_first", {16'd0, mem[16'h01F4]}, 32'h0000);
        chk("t1_mem_last", {16'd0, mem[16'h01FF]}, 32'hBBBB);
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_done_latency", 32'((first_done_cyc - last_wr_cyc) <= 3), 32'd1);
        chk("t1_br_released", {31'd0, BR}, 32'd0);

        // 2: zero length never requests the bus
        clear_mon(16'h0200);
        start(16'h0200, 4'd0);
        chk("t2_br_low", {30'd0, BR, done}, 32'd0);
        tick();
        chk("t2_done_high", {31'd0, done}, 32'd1);
        tick();
        chk("t2_done_low", {31'd0, done}, 32'd0);
        chk("t2_br_never", {31'd0, br_ever}, 32'd0);
        chk("t2_no_writes", 32'(wr_cnt), 32'd0);

        // 3: length 15 clamps to 12; a cmd while busy is ignored
        clear_mon(16'h0300);
        start(16'h0300, 4'd15);
        cmd_addr = 16'h0BAD; cmd_len = 4'd3; cmd = 1'b1;
        tick();
        cmd = 1'b0;
        wait_done(40);
        repeat (5) tick();
        chk("t3_writes", 32'(wr_cnt), 32'd12);
        chk("t3_last_idx", {28'd0, last_idx}, 32'd11);
        chk("t3_seq", 32'(seq_err), 32'd0);
        chk("t3_idle_after", {31'd0, BR}, 32'd0);

        // 4: grant withdrawn for 3 cycles after the 5th write
        clear_mon(16'h0400);
        start(16'h0400, 4'd12);
        for (int n = 0; n < 40 && wr_cnt < 5; n++) tick();
        chk("t4_pre_preempt", 32'(wr_cnt), 32'd5);
        bg_block = 1'b1;
        BG = 1'b0;
        tick();
        chk("t4_preempt_bus", {30'd0, use_bus, mem_write}, 32'd0);
        chk("t4_preempt_br", {31'd0, BR}, 32'd1);
        chk("t4_preempt_cnt", 32'(wr_cnt), 32'd5);
        tick(); tick();
        bg_block = 1'b0;
        BG = 1'b1;
        tick();
        chk("t4_resume", {27'd0, mem_write, idx}, {27'd0, 1'b1, 4'd5});
        wait_done(40);
        chk("t4_writes", 32'(wr_cnt), 32'd12);
        chk("t4_dups", 32'(dup_cnt), 32'd0);
        chk("t4_seq", 32'(seq_err), 32'd0);

        // 5: bus tenures for a 10-word transfer
        clear_mon(16'h0500);
        start(16'h0500, 4'd10);
        wait_done(80);
        chk("t5_writes", 32'(wr_cnt), 32'd10);
        chk("t5_seq", 32'(seq_err), 32'd0);
`ifdef DMA_BURST_RELEASE_EN
        chk("t5_tenures", 32'(tenures.size()), 32'd3);
        chk("t5_ten0", 32'(ten(0)), 32'd4);
        chk("t5_ten1", 32'(ten(1)), 32'd4);
        chk("t5_ten2", 32'(ten(2)), 32'd2);
`else
        chk("t5_tenures", 32'(tenures.size()), 32'd1);
        chk("t5_ten0", 32'(ten(0)), 32'd10);
`endif

        // 6: async reset mid-transfer, then a fresh command
        clear_mon(16'h0600);
        start(16'h0600, 4'd12);
        for (int n = 0; n < 40 && idx != 4'd6; n++) tick();
        chk("t6_at_idx6", {28'd0, idx}, 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_reset_now", {8'd0, BR, use_bus, mem_write, done, idx, mem_addr}, 32'd0);
        BG = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_reset_hold", {8'd0, BR, use_bus, mem_write, done, idx, mem_addr}, 32'd0);
        reset_n = 1'b1;
        tick();
        clear_mon(16'h0700);
        start(16'h0700, 4'd3);
        wait_done(40);
        chk("t6_first_idx", {28'd0, first_idx}, 32'd0);
        chk("t6_writes", 32'(wr_cnt), 32'd3);
        chk("t6_seq", 32'(seq_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
